// File: rtl/tc4_gf2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tc4_gf2_pkg
// Description : Shared constants, FSM state type and limb offset helper for
//               the time-shared four-way GF(2)[x] limb product scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package tc4_gf2_pkg;

    localparam int unsigned LIMB  = 71;
    localparam int unsigned NLIMB = 4;
    localparam int unsigned NPROD = NLIMB * NLIMB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Bit offset of limb product a_i*b_k inside the accumulator, with
    // i = p[3:2] and k = p[1:0].
    function automatic int unsigned limb_offset(input logic [3:0] p);
        return LIMB * (32'(p[3:2]) + 32'(p[1:0]));
    endfunction

endpackage
`default_nettype wire

// File: rtl/gf2_limb_mul_serial.sv
`default_nettype none
// ============================================================================
// Module      : gf2_limb_mul_serial
// Description : Bit-serial LIMB x LIMB carry-less multiplier. A start pulse
//               clears the partial; each following cycle consumes one bit of
//               a_limb (LSB first) and XORs b_limb << bit into the partial.
//               done is high during the cycle that consumes the last bit.
//               The limb inputs are read live and must stay stable while
//               the multiplier runs.
// Revision    : 1.0 - initial release
// ============================================================================
module gf2_limb_mul_serial #(
    parameter int unsigned LIMB = 71
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                cancel,
    input  logic [LIMB-1:0]     a_limb,
    input  logic [LIMB-1:0]     b_limb,
    output logic                done,
    output logic [2*LIMB-1:0]   partial
);

    localparam int unsigned           c_CW   = $clog2(LIMB);
    localparam logic [c_CW-1:0]       c_LAST = c_CW'(LIMB - 1);

    logic [c_CW-1:0]   r_bit;
    logic              r_run;
    logic [2*LIMB-1:0] r_partial;
    logic [2*LIMB-1:0] w_b_ext;

    // Zero-extend b so it can be shifted into any partial position.
    always_comb begin
        w_b_ext             = '0;
        w_b_ext[LIMB-1:0]   = b_limb;
    end

    // Shift-and-XOR engine: one multiplier bit per cycle while running.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit     <= '0;
            r_run     <= 1'b0;
            r_partial <= '0;
        end else if (start) begin
            r_bit     <= '0;
            r_run     <= 1'b1;
            r_partial <= '0;
        end else if (cancel) begin
            r_run     <= 1'b0;
        end else if (r_run) begin
            if (a_limb[r_bit]) begin
                r_partial <= r_partial ^ (w_b_ext << r_bit);
            end
            if (done) begin
                r_run <= 1'b0;
            end else begin
                r_bit <= r_bit + c_CW'(1);
            end
        end
    end

    assign done    = r_run && (r_bit == c_LAST);
    assign partial = r_partial;

endmodule
`default_nettype wire

// File: rtl/tc4_gf2_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tc4_gf2_mul_scheduler
// Description : 283x283 carry-less product computed by time-sharing one
//               bit-serial limb multiplier across the 16 four-way limb
//               products a_i*b_k, shift-accumulated at LIMB*(i+k).
//               Optional build macro ZERO_LIMB_SKIP_EN: skip limb products
//               whose a_i limb is zero (data-dependent latency). Left
//               undefined, latency is constant at 1+16*(LIMB+1) cycles.
//               LIMB must match tc4_gf2_pkg::LIMB (offset helper).
// Revision    : 1.0 - initial release
// ============================================================================
module tc4_gf2_mul_scheduler #(
    parameter int unsigned WIDTH = 283,
    parameter int unsigned LIMB  = tc4_gf2_pkg::LIMB
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   c,
    output logic                 busy
);
    import tc4_gf2_pkg::*;

    localparam int unsigned c_OPW  = 4 * LIMB;
    localparam int unsigned c_ACCW = 8 * LIMB;
    localparam int unsigned c_PW   = 2 * LIMB;

    state_t              r_state;
    state_t              w_state_next;
    logic [3:0]          r_p;
    logic [c_OPW-1:0]    r_a;
    logic [c_OPW-1:0]    r_b;
    logic [c_OPW-1:0]    w_a_pad;
    logic [c_OPW-1:0]    w_b_pad;
    logic [c_ACCW-1:0]   r_acc;
    logic [c_ACCW-1:0]   w_part_ext;
    logic [c_ACCW-1:0]   w_acc_next;
    logic [2*WIDTH-1:0]  r_c;
    logic [LIMB-1:0]     w_a_limb;
    logic [LIMB-1:0]     w_b_limb;
    logic [c_PW-1:0]     w_partial;
    logic                w_mul_done;
    logic                w_start;
    logic                w_cancel;
    logic                w_take;
    logic                w_skip;
    logic                w_acc_en;
    logic                w_last;
    logic                w_unused;

    // Zero-pad operands to four full limbs.
    always_comb begin
        w_a_pad            = '0;
        w_b_pad            = '0;
        w_a_pad[WIDTH-1:0] = a;
        w_b_pad[WIDTH-1:0] = b;
    end

    // Limb select muxes: i = p[3:2] picks from a, k = p[1:0] picks from b.
    assign w_a_limb = r_a[32'(r_p[3:2]) * LIMB +: LIMB];
    assign w_b_limb = r_b[32'(r_p[1:0]) * LIMB +: LIMB];

    // Place the finished partial at its limb offset and fold it in.
    always_comb begin
        w_part_ext             = '0;
        w_part_ext[c_PW-1:0]   = w_partial;
        w_acc_next             = r_acc ^ (w_part_ext << limb_offset(r_p));
    end

`ifdef ZERO_LIMB_SKIP_EN
    // A zero a_i limb yields a zero product; leave MUL after one cycle.
    assign w_skip = (w_a_limb == '0);
`else
    assign w_skip = 1'b0;
`endif

    assign w_take = (r_state == IDLE) && in_valid && !abort;
    assign w_last = (r_p == 4'(NPROD - 1));

    // Next-state logic and multiplier / accumulator control strobes.
    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_cancel     = abort;
        w_acc_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_state_next = MUL;
                    w_start      = 1'b1;
                end
            end
            MUL: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else if (w_skip) begin
                    // Stopping the multiplier keeps the cleared partial at 0,
                    // so the following ACC cycle adds nothing.
                    w_state_next = ACC;
                    w_cancel     = 1'b1;
                end else if (w_mul_done) begin
                    w_state_next = ACC;
                end
            end
            ACC: begin
                if (abort) begin
                    w_state_next = IDLE;
                end else begin
                    w_acc_en = 1'b1;
                    if (w_last) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = MUL;
                        w_start      = 1'b1;
                    end
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Operand latch, product index, accumulator and result register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
            r_p   <= '0;
            r_c   <= '0;
        end else if (w_take) begin
            r_a   <= w_a_pad;
            r_b   <= w_b_pad;
            r_acc <= '0;
            r_p   <= '0;
        end else if (w_acc_en) begin
            r_acc <= w_acc_next;
            if (w_last) begin
                r_c <= w_acc_next[2*WIDTH-1:0];
            end else begin
                r_p <= r_p + 4'd1;
            end
        end
    end

    gf2_limb_mul_serial #(
        .LIMB    (LIMB)
    ) u_limb_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_start),
        .cancel  (w_cancel),
        .a_limb  (w_a_limb),
        .b_limb  (w_b_limb),
        .done    (w_mul_done),
        .partial (w_partial)
    );

    // Accumulator bits above the product width are always zero.
    assign w_unused = ^r_acc[c_ACCW-1:2*WIDTH];

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign c         = r_c;

endmodule
`default_nettype wire

// File: tb/tb_tc4_gf2_mul_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_tc4_gf2_mul_scheduler
// Description : Directed self-checking bench for tc4_gf2_mul_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tc4_gf2_mul_scheduler;

    localparam int W  = 283;
    localparam int CW = 2 * W;
`ifdef ZERO_LIMB_SKIP_EN
    localparam int LAT_ONE = 313;
`else
    localparam int LAT_ONE = 1153;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          abort;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] c;
    logic          busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tc4_gf2_mul_scheduler #(
        .WIDTH     (W),
        .LIMB      (71)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .busy      (busy)
    );

    // Handshake one operand pair; returns #1 after the accepting edge.
    task automatic start_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        @(negedge clk);
        a        = op_a;
        b        = op_b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Start an operation and wait (bounded) for out_valid.
    // cyc counts the handshake cycle as 0 and the first MUL cycle as 1.
    task automatic do_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                         output int cyc, output bit rdy_seen, output bit timeout);
        start_op(op_a, op_b);
        cyc      = 1;
        rdy_seen = 1'b0;
        timeout  = 1'b0;
        while (!out_valid && !timeout) begin
            if (in_ready || !busy) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            if (cyc > 5000) timeout = 1'b1;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
        a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (c !== '0) begin errors++; $display("FAIL reset_c: got %h expected 0", c); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unit_product();
        int cyc; bit rdy; bit to;
        logic [CW-1:0] exp;
        exp = '0; exp[0] = 1'b1;
        out_ready = 1'b1;
        do_op(283'd1, 283'd1, cyc, rdy, to);
        checks++; if (to) begin errors++; $display("FAIL unit_timeout: got no out_valid expected out_valid within 5000 cycles"); end
        checks++; if (cyc != LAT_ONE) begin errors++; $display("FAIL unit_latency: got %0d expected %0d", cyc, LAT_ONE); end
        checks++; if (rdy) begin errors++; $display("FAIL unit_in_ready_busy: got in_ready=1 or busy=0 during operation expected in_ready=0 busy=1"); end
        checks++; if (c !== exp) begin errors++; $display("FAIL unit_c: got %h expected %h", c, exp); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL unit_return_idle: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
        checks++; if (c !== exp) begin errors++; $display("FAIL unit_c_hold_idle: got %h expected %h", c, exp); end
    endtask

    task automatic test_small_products();
        logic [W-1:0]  va [2];
        logic [W-1:0]  vb [2];
        logic [CW-1:0] ve [2];
        int cyc; bit rdy; bit to;
        va[0] = 283'd3; vb[0] = 283'd3; ve[0] = 566'd5;
        va[1] = '0; va[1][282] = 1'b1;
        vb[1] = '0; vb[1][282] = 1'b1;
        ve[1] = '0; ve[1][564] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            do_op(va[t], vb[t], cyc, rdy, to);
            checks++; if (to || c !== ve[t]) begin errors++; $display("FAIL small_c[%0d]: got %h expected %h", t, c, ve[t]); end
            release_result();
        end
    endtask

    task automatic test_limb_boundary();
        logic [W-1:0]  va [2];
        logic [W-1:0]  vb [2];
        logic [CW-1:0] ve [2];
        int cyc; bit rdy; bit to;
        va[0] = '1; vb[0] = 283'd1;
        ve[0] = '0; ve[0][282:0] = '1;
        va[1] = '0; va[1][71] = 1'b1; va[1][0] = 1'b1;
        vb[1] = va[1];
        ve[1] = '0; ve[1][142] = 1'b1; ve[1][0] = 1'b1;
        for (int t = 0; t < 2; t++) begin
            do_op(va[t], vb[t], cyc, rdy, to);
            checks++; if (to || c !== ve[t]) begin errors++; $display("FAIL limb_c[%0d]: got %h expected %h", t, c, ve[t]); end
            release_result();
        end
    endtask

    task automatic test_backpressure();
        int cyc; bit rdy; bit to;
        int bad;
        logic [W-1:0]  op_a;
        logic [CW-1:0] exp;
        op_a = '0; op_a[70] = 1'b1;
        exp  = '0; exp[71] = 1'b1;
        do_op(op_a, 283'd2, cyc, rdy, to);
        checks++; if (to || out_valid !== 1'b1 || c !== exp) begin errors++; $display("FAIL bp_result: got valid=%b c=%h expected valid=1 c=%h", out_valid, c, exp); end
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            in_valid = (i % 3 == 0);
            a = W'($urandom);
            b = W'($urandom);
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || c !== exp) bad++;
        end
        in_valid = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
        release_result();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0 || c !== exp) begin errors++; $display("FAIL bp_no_queue: got busy=%b c=%h expected busy=0 c=%h", busy, c, exp); end
    endtask

    task automatic test_reset_mid_op();
        start_op(283'd3, 283'd3);
        repeat (499) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_state: got out_valid=%b busy=%b expected 0 0", out_valid, busy); end
        checks++; if (c !== '0) begin errors++; $display("FAIL rst_mid_c: got %h expected 0", c); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_abort();
        int cyc; bit rdy; bit to;
        int seen;
        logic [W-1:0]  op;
        logic [CW-1:0] prev;
        logic [CW-1:0] one;
        op   = '0; op[71] = 1'b1; op[0] = 1'b1;
        prev = '0; prev[142] = 1'b1; prev[0] = 1'b1;
        one  = '0; one[0] = 1'b1;
        do_op(op, op, cyc, rdy, to);
        release_result();
        checks++; if (c !== prev) begin errors++; $display("FAIL abort_setup_c: got %h expected %h", c, prev); end
        start_op(283'd3, 283'd3);
        repeat (499) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b in_ready=%b out_valid=%b expected 0 1 0", busy, in_ready, out_valid); end
        checks++; if (c !== prev) begin errors++; $display("FAIL abort_c_kept: got %h expected %h", c, prev); end
        seen = 0;
        for (int i = 0; i < 1300; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_out_valid: got %0d valid cycles expected 0", seen); end
        @(negedge clk);
        in_valid = 1'b1; abort = 1'b1; a = 283'd1; b = 283'd1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_wins_idle: got busy=%b expected 0", busy); end
        do_op(283'd1, 283'd1, cyc, rdy, to);
        checks++; if (cyc != LAT_ONE) begin errors++; $display("FAIL abort_next_latency: got %0d expected %0d", cyc, LAT_ONE); end
        checks++; if (c !== one) begin errors++; $display("FAIL abort_next_c: got %h expected %h", c, one); end
        release_result();
    endtask

    initial begin
        test_reset();
        test_unit_product();
        test_small_products();
        test_limb_boundary();
        test_backpressure();
        test_reset_mid_op();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
